// File: rtl/spi_write_decoder.sv
// SPI write-frame decoder: command 0x02, address, then a stream of data bytes
// pushed as {addr,data} write requests. SPI_WRITE_DECODER_STATS_EN builds frame_count.
module spi_write_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic [7:0]            mosi,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  cmd_err,
    output logic                  overflow,
    output logic [15:0]           frame_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ADDR_WIDTH + 8;
    localparam logic [2:0] LAST = 3'(ADDR_WIDTH / 8 - 1);
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DISCARD} state_t;

    state_t                state;
    logic                  armed;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr, rd_next;
    logic [PW:0]           count, count_next;
    logic                  pop, push_req, push, drop;
    logic [EW-1:0]         entry, head_next;

    always_comb begin
        pop        = wr_valid & wr_ready;
        push_req   = !cs && (state == DATA);
        push       = push_req && ((count != FULL) || pop);
        drop       = push_req && (count == FULL) && !pop;
        entry      = {addr, mosi};
        rd_next    = rd_ptr + PW'(pop);
        count_next = count + (PW + 1)'(push) - (PW + 1)'(pop);
        // With nothing left behind the popped head, the new head is the byte being pushed.
        head_next  = (count == (PW + 1)'(pop)) ? entry : mem[rd_next];
    end

    always_ff @(posedge sclk) begin
        if (rst_n && push)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            cnt      <= '0;
            addr     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cmd_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cmd_err  <= 1'b0;
            rd_ptr   <= rd_next;
            count    <= count_next;
            wr_valid <= (count_next != '0);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (count_next != '0)
                {wr_addr, wr_data} <= head_next;
            if (drop)
                overflow <= 1'b1;
            if (cs) begin
                state <= IDLE;
                armed <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        // After a reset the rest of an open frame is ignored until cs rises.
                        if (armed) begin
                            if (mosi == 8'h02) begin
                                state <= ADDR;
                                cnt   <= '0;
                            end else begin
                                cmd_err <= 1'b1;
                                state   <= DISCARD;
                            end
                        end
                    end
                    ADDR: begin
                        addr <= (addr << 8) | ADDR_WIDTH'(mosi);
                        cnt  <= cnt + 3'd1;
                        if (cnt == LAST)
                            state <= DATA;
                    end
                    DATA:    addr <= addr + ADDR_WIDTH'(1);
                    DISCARD: state <= DISCARD;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_WRITE_DECODER_STATS_EN
    logic        hit;
    logic [15:0] fcnt;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            hit  <= 1'b0;
            fcnt <= '0;
        end else if (cs) begin
            if (hit && fcnt != 16'hFFFF)
                fcnt <= fcnt + 16'd1;
            hit <= 1'b0;
        end else if (push || drop) begin
            hit <= 1'b1;
        end
    end

    assign frame_count = fcnt;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_spi_write_decoder.sv
// Bench for spi_write_decoder: table of frames plus stall, abort and reset
// sequences, with a request scoreboard checked at the handshake.
module tb_spi_write_decoder;

    logic        sclk;
    logic        rst_n;
    logic        cs;
    logic [7:0]  mosi;
    logic        wr_valid;
    logic        wr_ready;
    logic [23:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cmd_err;
    logic        overflow;
    logic [15:0] frame_count;

    spi_write_decoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(24)) dut (
        .sclk(sclk), .rst_n(rst_n), .cs(cs), .mosi(mosi),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_err(cmd_err), .overflow(overflow),
        .frame_count(frame_count)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
        int          due;
    } exp_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        logic [31:0] d;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   err_cnt = 0;
    int   exp_frames = 0;

    always @(posedge sclk) cyc++;

    // Scoreboard: the handshake of the coming edge is judged half a cycle early.
    always begin
        exp_t e;
        @(negedge sclk);
        #1;
        if (cmd_err === 1'b1)
            err_cnt++;
        if (wr_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_req: got addr=%06h data=%02h want none",
                         wr_addr, wr_data);
            end else begin
                e = sb[0];
                if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
                    bad++;
                    $display("FAIL req: got %06h/%02h want %06h/%02h",
                             wr_addr, wr_data, e.addr, e.data);
                end
                if (wr_ready === 1'b1) begin
                    if (e.due >= 0) begin
                        total++;
                        if (cyc != e.due) begin
                            bad++;
                            $display("FAIL latency: got cycle %0d want %0d", cyc, e.due);
                        end
                    end
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_fc();
`ifdef SPI_WRITE_DECODER_STATS_EN
        return 32'(exp_frames);
`else
        return 32'd0;
`endif
    endfunction

    task automatic drive(input logic [7:0] b);
        @(negedge sclk);
        cs   = 1'b0;
        mosi = b;
    endtask

    task automatic end_frame();
        @(negedge sclk);
        cs   = 1'b1;
        mosi = 8'h00;
        @(negedge sclk);
    endtask

    task automatic expect_req(input logic [23:0] a, input logic [7:0] d, input int due);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.due  = due;
        sb.push_back(e);
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] b;
        drive(v.cmd);
        for (int i = 0; i < 3; i++)
            drive(v.addr[23-8*i -: 8]);
        for (int i = 0; i < v.n; i++) begin
            b = v.d[31-8*i -: 8];
            drive(b);
            if (v.cmd == 8'h02)
                expect_req(v.addr + 24'(i), b, cyc + 1);
        end
        end_frame();
        if (v.cmd == 8'h02 && v.n > 0)
            exp_frames++;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge sclk);
            k++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge sclk);
    endtask

    vec_t vt[7];
    vec_t v;
    int   e0;

    initial begin
        vt[0] = '{8'h02, 24'h001000, 2, 32'hAABB0000};
        vt[1] = '{8'h02, 24'hFFFFFF, 2, 32'h11220000};
        vt[2] = '{8'h03, 24'h000000, 1, 32'h55000000};
        vt[3] = '{8'h02, 24'h000005, 1, 32'h66000000};
        vt[4] = '{8'h02, 24'h123456, 4, 32'h01020304};
        vt[5] = '{8'h02, 24'h0000FF, 0, 32'h00000000};
        vt[6] = '{8'hA5, 24'h000001, 2, 32'h77880000};

        rst_n    = 1'b0;
        cs       = 1'b1;
        mosi     = 8'h00;
        wr_ready = 1'b1;
        repeat (3) @(negedge sclk);
        chk("rst_valid", 32'(wr_valid), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_err", 32'(cmd_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            e0 = err_cnt;
            send_frame(vt[k]);
            wait_drain();
            chk("cmd_err_cnt", 32'(err_cnt - e0), (vt[k].cmd != 8'h02) ? 32'd1 : 32'd0);
            chk("frame_count", 32'(frame_count), exp_fc());
        end
        chk("ovf_clean", 32'(overflow), 32'd0);

        // Stalled sink: four held, two dropped, then a push that meets a pop.
        @(negedge sclk);
        wr_ready = 1'b0;
        drive(8'h02);
        for (int i = 0; i < 3; i++)
            drive(8'h00);
        for (int i = 0; i < 6; i++) begin
            drive(8'hC0 + 8'(i));
            if (i < 4)
                expect_req(24'(i), 8'hC0 + 8'(i), -1);
        end
        @(negedge sclk);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("stall_valid", 32'(wr_valid), 32'd1);
        wr_ready = 1'b1;
        mosi     = 8'hC6;
        expect_req(24'h000006, 8'hC6, -1);
        end_frame();
        exp_frames++;
        wait_drain();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("fc_stall", 32'(frame_count), exp_fc());

        // Abort after a partial address, then a clean frame.
        e0 = err_cnt;
        drive(8'h02);
        drive(8'h00);
        end_frame();
        chk("abort_none", 32'(sb.size()), 32'd0);
        v = '{8'h02, 24'h000007, 1, 32'h77000000};
        send_frame(v);
        wait_drain();
        chk("abort_err", 32'(err_cnt - e0), 32'd0);

        // Reset in the middle of a data phase.
        wr_ready = 1'b0;
        drive(8'h02);
        drive(8'h00);
        drive(8'h00);
        drive(8'h20);
        drive(8'h31);
        expect_req(24'h000020, 8'h31, -1);
        drive(8'h32);
        expect_req(24'h000021, 8'h32, -1);
        @(negedge sclk);
        rst_n = 1'b0;
        mosi  = 8'h33;
        @(negedge sclk);
        sb.delete();
        exp_frames = 0;
        chk("mid_valid", 32'(wr_valid), 32'd0);
        chk("mid_addr", 32'(wr_addr), 32'd0);
        chk("mid_data", 32'(wr_data), 32'd0);
        chk("mid_err", 32'(cmd_err), 32'd0);
        chk("mid_ovf", 32'(overflow), 32'd0);
        chk("mid_fc", 32'(frame_count), 32'd0);
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        e0       = err_cnt;
        drive(8'h02);
        drive(8'h00);
        drive(8'h00);
        drive(8'h09);
        drive(8'h44);
        drive(8'h03);
        end_frame();
        wait_drain();
        chk("post_rst_err", 32'(err_cnt - e0), 32'd0);

        // Three good frames after reset.
        for (int k = 0; k < 3; k++) begin
            v = '{8'h02, 24'h000100 + 24'(k * 16), 1, {8'h90 + 8'(k), 24'h0}};
            send_frame(v);
        end
        wait_drain();
        chk("fc_three", 32'(frame_count), exp_fc());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
